// File: rtl/memory_arbiter.sv
// Two-port (fetch / data) round-robin arbiter in front of a single-port synchronous memory,
// with registered memory controls and a two-stage read-response pipeline.
module memory_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_a,
    output logic              f_gnt,
    output logic              f_rvalid,
    input  logic              d_req,
    input  logic              d_rw,
    input  logic [ADDR_W-1:0] d_a,
    input  logic [DATA_W-1:0] d_din,
    input  logic              d_lock,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_rw,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DATA  = 1'b1
    } port_e;

    port_e             last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic              mem_rw_q, mem_rw_d;
    logic              rsp1_vld_q, rsp1_vld_d;
    port_e             rsp1_port_q, rsp1_port_d;
    logic              rsp2_vld_q, rsp2_vld_d;
    port_e             rsp2_port_q, rsp2_port_d;
    logic              lock_hold;
    logic              f_gnt_c;
    logic              d_gnt_c;

    // Arbitration: data holds the memory while locked, otherwise round-robin on contention
    always_comb begin
        f_gnt_c   = 1'b0;
        d_gnt_c   = 1'b0;
        lock_hold = d_lock && (last_grant_q == PORT_DATA);
        if (!rst) begin
            if (d_req && (lock_hold || !f_req || last_grant_q == PORT_FETCH)) begin
                d_gnt_c = 1'b1;
            end else if (f_req && !lock_hold) begin
                f_gnt_c = 1'b1;
            end
        end
    end

    // Next state: the memory command only carries write data for data-port grants
    always_comb begin
        last_grant_d = last_grant_q;
        mem_a_d      = mem_a_q;
        mem_din_d    = mem_din_q;
        mem_rw_d     = 1'b0;
        rsp1_vld_d   = 1'b0;
        rsp1_port_d  = rsp1_port_q;
        rsp2_vld_d   = rsp1_vld_q;
        rsp2_port_d  = rsp1_port_q;
        if (d_gnt_c) begin
            last_grant_d = PORT_DATA;
            mem_a_d      = d_a;
            mem_din_d    = d_din;
            mem_rw_d     = d_rw;
            rsp1_vld_d   = !d_rw;
            rsp1_port_d  = PORT_DATA;
        end else if (f_gnt_c) begin
            last_grant_d = PORT_FETCH;
            mem_a_d      = f_a;
            rsp1_vld_d   = 1'b1;
            rsp1_port_d  = PORT_FETCH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= PORT_FETCH;
            mem_a_q      <= '0;
            mem_din_q    <= '0;
            mem_rw_q     <= 1'b0;
            rsp1_vld_q   <= 1'b0;
            rsp1_port_q  <= PORT_FETCH;
            rsp2_vld_q   <= 1'b0;
            rsp2_port_q  <= PORT_FETCH;
        end else begin
            last_grant_q <= last_grant_d;
            mem_a_q      <= mem_a_d;
            mem_din_q    <= mem_din_d;
            mem_rw_q     <= mem_rw_d;
            rsp1_vld_q   <= rsp1_vld_d;
            rsp1_port_q  <= rsp1_port_d;
            rsp2_vld_q   <= rsp2_vld_d;
            rsp2_port_q  <= rsp2_port_d;
        end
    end

    assign f_gnt    = f_gnt_c;
    assign d_gnt    = d_gnt_c;
    assign f_rvalid = rsp2_vld_q && (rsp2_port_q == PORT_FETCH);
    assign d_rvalid = rsp2_vld_q && (rsp2_port_q == PORT_DATA);
    assign rdata    = mem_dout;
    assign mem_a    = mem_a_q;
    assign mem_din  = mem_din_q;
    assign mem_rw   = mem_rw_q;

endmodule
